// File: rtl/bp_pkg.sv
// Shared types and constants for the branch resolve stage and its training FIFO.
// Contents:
//   PC_STEP      sequential fetch increment
//   bru_state_e  resolve-stage FSM states (RUN, SQUASH)
//   train_rec_t  one training record handed to the gselect predictor
//   next_pc()    architecturally correct successor of a resolved instruction
package bp_pkg;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } bru_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        isbranch;
    logic        taken;
  } train_rec_t;

  // Only a taken branch leaves the sequential path; the sum wraps modulo 2^32.
  function automatic logic [31:0] next_pc(input logic [31:0] pc,
                                          input logic        isbranch,
                                          input logic        taken,
                                          input logic [31:0] target);
    return (isbranch && taken) ? target : pc + PC_STEP;
  endfunction

endpackage

// File: rtl/bp_train_fifo.sv
// Training record FIFO: up to two pushes and two pops per cycle, registered read side.
// Ports:
//   clk, rst          clock, synchronous active-high reset (empties the FIFO)
//   push_count        number of records to write this cycle (0..2)
//   push_rec0/1       records to write; rec0 is the older one
//   hold              consumer stalled: no pop, outputs invalid next cycle
//   count             current occupancy (registered)
//   out_valid0/1      registered pop results; out_valid1 implies out_valid0
//   out_rec0/1        popped records, oldest in rec0
module bp_train_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               push_count,
  input  train_rec_t               push_rec0,
  input  train_rec_t               push_rec1,
  input  logic                     hold,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     out_valid0,
  output logic                     out_valid1,
  output train_rec_t               out_rec0,
  output train_rec_t               out_rec1
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  train_rec_t      mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr_n1;
  logic [PW-1:0]   wr_ptr_n1;
  logic [1:0]      pop_count;

  // DEPTH is a power of two, so pointer arithmetic wraps for free.
  assign rd_ptr_n1 = rd_ptr + PW'(1);
  assign wr_ptr_n1 = wr_ptr + PW'(1);

  // Pop as much as is stored, at most two, based only on the registered count.
  always_comb begin
    pop_count = 2'd0;
    if (!hold) begin
      pop_count = (count >= CW'(2)) ? 2'd2 : count[1:0];
    end
  end

  // Storage has no reset; a reset only needs to rewind the pointers.
  always_ff @(posedge clk) begin
    if (push_count != 2'd0) begin
      mem[wr_ptr] <= push_rec0;
    end
    if (push_count == 2'd2) begin
      mem[wr_ptr_n1] <= push_rec1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      out_valid0 <= 1'b0;
      out_valid1 <= 1'b0;
      out_rec0   <= '0;
      out_rec1   <= '0;
    end else begin
      wr_ptr     <= wr_ptr + PW'(push_count);
      rd_ptr     <= rd_ptr + PW'(pop_count);
      count      <= count + CW'(push_count) - CW'(pop_count);
      out_valid0 <= (pop_count != 2'd0);
      out_valid1 <= (pop_count == 2'd2);
      out_rec0   <= (pop_count != 2'd0) ? mem[rd_ptr] : '0;
      out_rec1   <= (pop_count == 2'd2) ? mem[rd_ptr_n1] : '0;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Dual-slot branch resolution: detects mispredicts, issues a one-cycle fetch redirect,
// squashes wrong-path input for SQUASH_CYC cycles and queues training records for the
// gselect predictor. Slot 0 is always the older instruction.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   res_valid/pc/isbranch/taken/target/pred_target 0/1   resolved instruction inputs
//   res_ready                     inputs accepted this cycle
//   redirect_valid, redirect_pc   registered refetch request
//   train_hold                    predictor stall
//   train_valid/isbranch/taken/address_branch/address_result 0/1   training records
//   cnt_branches, cnt_mispredict  wrapping event counters
module branch_resolve_unit
  import bp_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int SQUASH_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        res_valid0,
  input  logic        res_valid1,
  input  logic [31:0] res_pc0,
  input  logic [31:0] res_pc1,
  input  logic        res_isbranch0,
  input  logic        res_isbranch1,
  input  logic        res_taken0,
  input  logic        res_taken1,
  input  logic [31:0] res_target0,
  input  logic [31:0] res_target1,
  input  logic [31:0] pred_target0,
  input  logic [31:0] pred_target1,
  output logic        res_ready,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        train_hold,
  output logic        train_valid0,
  output logic        train_valid1,
  output logic        isbranch0,
  output logic        isbranch1,
  output logic        taken0,
  output logic        taken1,
  output logic [31:0] address_branch0,
  output logic [31:0] address_branch1,
  output logic [31:0] address_result0,
  output logic [31:0] address_result1,
  output logic [31:0] cnt_branches,
  output logic [31:0] cnt_mispredict
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = (SQUASH_CYC > 1) ? $clog2(SQUASH_CYC) : 1;

  bru_state_e    state, state_next;
  logic [SW-1:0] squash_cnt, squash_cnt_next;
  logic [CW-1:0] fifo_count;

  logic [31:0]   actual0, actual1;
  logic          mispred0, mispred1;
  logic          acc0, acc1, mis0, mis1, any_mis;
  logic          enq0, enq1;
  logic [1:0]    push_count;
  logic [1:0]    branch_inc;
  train_rec_t    rec0, rec1, push_rec0, push_rec1, out_rec0, out_rec1;

  // Two free entries guarantee a 2-wide push always fits, even under train_hold.
  assign res_ready = (state == RUN) && (fifo_count <= CW'(DEPTH - 2));

  assign actual0  = next_pc(res_pc0, res_isbranch0, res_taken0, res_target0);
  assign actual1  = next_pc(res_pc1, res_isbranch1, res_taken1, res_target1);
  assign mispred0 = (pred_target0 != actual0);
  assign mispred1 = (pred_target1 != actual1);

  // A slot-0 mispredict makes slot 1 wrong-path, so it is never accepted.
  assign acc0    = res_valid0 && res_ready;
  assign acc1    = res_valid1 && res_ready && !(acc0 && mispred0);
  assign mis0    = acc0 && mispred0;
  assign mis1    = acc1 && mispred1;
  assign any_mis = mis0 || mis1;

  // A mispredicting non-branch (false BTB hit) still trains, with isbranch=0.
  assign enq0 = acc0 && (res_isbranch0 || mispred0);
  assign enq1 = acc1 && (res_isbranch1 || mispred1);

  assign rec0 = '{pc: res_pc0, target: res_target0, isbranch: res_isbranch0, taken: res_taken0};
  assign rec1 = '{pc: res_pc1, target: res_target1, isbranch: res_isbranch1, taken: res_taken1};

  // Compact enqueued records so the oldest always lands in push slot 0.
  always_comb begin
    push_count = 2'd0;
    push_rec0  = '0;
    push_rec1  = '0;
    if (enq0) begin
      push_rec0  = rec0;
      push_rec1  = rec1;
      push_count = enq1 ? 2'd2 : 2'd1;
    end else if (enq1) begin
      push_rec0  = rec1;
      push_count = 2'd1;
    end
  end

  assign branch_inc = {1'b0, enq0 && res_isbranch0} + {1'b0, enq1 && res_isbranch1};

  // Squash window: counter loaded with SQUASH_CYC-1 so res_ready stays low SQUASH_CYC cycles.
  always_comb begin
    state_next      = state;
    squash_cnt_next = squash_cnt;
    case (state)
      RUN: begin
        if (any_mis) begin
          state_next      = SQUASH;
          squash_cnt_next = SW'(SQUASH_CYC - 1);
        end
      end
      SQUASH: begin
        if (squash_cnt == '0) begin
          state_next = RUN;
        end else begin
          squash_cnt_next = squash_cnt - SW'(1);
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= RUN;
      squash_cnt     <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      cnt_branches   <= '0;
      cnt_mispredict <= '0;
    end else begin
      state          <= state_next;
      squash_cnt     <= squash_cnt_next;
      redirect_valid <= any_mis;
      if (any_mis) begin
        redirect_pc <= mis0 ? actual0 : actual1;
      end
      cnt_branches   <= cnt_branches + 32'(branch_inc);
      cnt_mispredict <= cnt_mispredict + 32'(any_mis);
    end
  end

  bp_train_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_count(push_count),
    .push_rec0 (push_rec0),
    .push_rec1 (push_rec1),
    .hold      (train_hold),
    .count     (fifo_count),
    .out_valid0(train_valid0),
    .out_valid1(train_valid1),
    .out_rec0  (out_rec0),
    .out_rec1  (out_rec1)
  );

  assign isbranch0       = out_rec0.isbranch;
  assign isbranch1       = out_rec1.isbranch;
  assign taken0          = out_rec0.taken;
  assign taken1          = out_rec1.taken;
  assign address_branch0 = out_rec0.pc;
  assign address_branch1 = out_rec1.pc;
  assign address_result0 = out_rec0.target;
  assign address_result1 = out_rec1.target;

endmodule
